conv_frame_sequencer: RTL and testbench
=======================================

// Module: conv_frame_sequencer
// PURPOSE
//   Frame-level controller for the `convolution` FIR datapath. Holds a shadow and an active coefficient
//   bank, latches the active bank at frame start, and streams frame_len samples into the datapath.
//   It then feeds N_TAPS-1 zero samples to flush the tail and collects frame_len+N_TAPS-1 outputs.
//   Sits between the sample source/host config and `convolution`; one frame in flight at a time.
// PARAMETERS
//   DATA_WIDTH  16  sample, coefficient and output width (signed)
//   N_TAPS      16  filter length; must match the datapath's N_TAPS (>=2)
//   LEN_W       16  width of frame_len and the internal counters
// PORTS
//   clk            in   1                  clock, all logic on rising edge
//   rst_n          in   1                  asynchronous active-low reset
//   start          in   1                  begin frame (honoured only in IDLE)
//   abort          in   1                  abandon current frame, return to IDLE
//   frame_len      in   LEN_W              samples in frame, sampled on accepted start
//   coef_wr_en     in   1                  write one shadow coefficient
//   coef_addr      in   $clog2(N_TAPS)     shadow index
//   coef_data      in   DATA_WIDTH         shadow value
//   s_valid        in   1                  input sample valid
//   s_data         in   DATA_WIDTH         input sample
//   s_ready        out  1                  sequencer accepts s_data this cycle
//   conv_valid_in  out  1                  to datapath valid_in
//   conv_x         out  DATA_WIDTH         to datapath x_in
//   conv_h         out  N_TAPS*DATA_WIDTH  active bank, tap k at [k*DATA_WIDTH +: DATA_WIDTH]
//   conv_valid_out in   1                  from datapath valid_out
//   conv_y         in   DATA_WIDTH         from datapath y_out
//   m_valid        out  1                  output sample valid
//   m_data         out  DATA_WIDTH         output sample
//   m_last         out  1                  final output of frame (with m_valid)
//   busy           out  1                  high in every state except IDLE
//   done           out  1                  one-cycle pulse at frame completion
// BEHAVIOUR
//   Reset: state IDLE; all outputs 0; both banks 0; counters 0.
//   FSM: IDLE -> STREAM on start (frame_len>0) | DONE on start (frame_len==0).
//     STREAM -> FLUSH after the frame_len-th accepted sample.
//     FLUSH -> DRAIN after N_TAPS-1 zero beats.
//     DRAIN -> DONE when the output count reaches frame_len+N_TAPS-1.
//     DONE -> IDLE unconditionally after 1 cycle; done=1 only in DONE.
//   Start cycle: active bank <= shadow (pre-write contents if coef_wr_en is in the same cycle).
//     frame_len is latched. start outside IDLE is ignored.
//   Shadow writes are accepted in any state. The active bank changes only at an accepted start,
//     so conv_h is stable for a whole frame.
//   STREAM: s_ready=1. On s_valid&s_ready, register conv_x<=s_data and conv_valid_in<=1 (1-cycle
//     latency). With no s_valid, drive conv_valid_in=0 (bubble; the datapath advances only on valid_in).
//   FLUSH: s_ready=0; conv_valid_in=1 and conv_x=0 for exactly N_TAPS-1 consecutive cycles.
//   DRAIN/DONE/IDLE: conv_valid_in=0, s_ready=0.
//   Outputs: m_valid<=conv_valid_out and m_data<=conv_y, registered (1-cycle latency). Counted only
//     in STREAM/FLUSH/DRAIN; ignored (m_valid stays 0) in IDLE/DONE, which drops stale outputs after abort.
//   m_last=1 with the (frame_len+N_TAPS-1)-th m_valid; done pulses on the next cycle.
//   Output counter is LEN_W+1 bits so frame_len=2^LEN_W-1 plus tail cannot wrap.
//   abort: highest priority in any state. Next state is IDLE; conv_valid_in, s_ready, m_valid = 0
//     next cycle; no done pulse. The active bank keeps its value.
//   No output backpressure: the consumer must sink one m_valid per cycle.
//   rst_n assertion mid-frame: immediate return to reset values, including the banks.
// TESTING
//   1. Shadow h=[1,0..0], start frame_len=4, x=1,2,3,4 back-to-back -> m_data 1,2,3,4 then 15 zeros.
//      Also require: m_last on the 19th output, done the next cycle, conv_valid_in high for 19 cycles.
//   2. h=[1,1,0..0], s_valid toggled 1/0, frame_len=3 x=5,6,7 -> bubbles on conv_valid_in.
//      Require outputs 5,11,13,7, then zeros, for 18 outputs total.
//   3. Write shadow h[0]=2 in the same cycle as start with shadow h[0]=1 -> frame uses 1.
//      Next frame uses 2; conv_h is unchanged across the frame while shadow writes occur.
//   4. start with frame_len=0 -> busy 1 cycle, done pulse, no conv_valid_in, no m_valid.
//   5. abort during FLUSH -> IDLE next cycle, no done, late conv_valid_out ignored.
//      A new start then runs a clean frame of correct length.
//   6. rst_n low mid-STREAM for 1 cycle, asynchronously -> outputs 0 immediately, banks cleared,
//      start ignored while rst_n=0.

Source files
------------

// File: rtl/conv_frame_sequencer.sv
// Frame-level controller for the convolution FIR datapath: double-buffered coefficient
// banks, sample streaming, zero-flush of the filter tail and output collection per frame.
module conv_frame_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int N_TAPS     = 16,
  parameter int LEN_W      = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           abort,
  input  logic [LEN_W-1:0]               frame_len,
  input  logic                           coef_wr_en,
  input  logic [$clog2(N_TAPS)-1:0]      coef_addr,
  input  logic [DATA_WIDTH-1:0]          coef_data,
  input  logic                           s_valid,
  input  logic [DATA_WIDTH-1:0]          s_data,
  output logic                           s_ready,
  output logic                           conv_valid_in,
  output logic [DATA_WIDTH-1:0]          conv_x,
  output logic [N_TAPS*DATA_WIDTH-1:0]   conv_h,
  input  logic                           conv_valid_out,
  input  logic [DATA_WIDTH-1:0]          conv_y,
  output logic                           m_valid,
  output logic [DATA_WIDTH-1:0]          m_data,
  output logic                           m_last,
  output logic                           busy,
  output logic                           done
);

  localparam int AW = $clog2(N_TAPS);
  localparam logic [AW:0]      TAP_COUNT  = (AW+1)'(N_TAPS);
  localparam logic [LEN_W:0]   TAIL       = (LEN_W+1)'(N_TAPS - 1);
  localparam logic [LEN_W-1:0] FLUSH_LAST = LEN_W'(N_TAPS - 2);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STREAM = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t                  state_r, next_state_s;
  logic [DATA_WIDTH-1:0]   shadow_r [N_TAPS];
  logic [LEN_W-1:0]        len_r, in_cnt_r, flush_cnt_r;
  logic [LEN_W:0]          out_cnt_r, total_s;
  logic                    accept_s, count_s, start_ok_s, in_last_s, flush_last_s;

  // Handshake qualifiers and next-state selection; abort overrides everything.
  always_comb begin
    total_s      = {1'b0, len_r} + TAIL;
    accept_s     = s_valid && s_ready;
    start_ok_s   = (state_r == ST_IDLE) && start && !abort;
    in_last_s    = accept_s && (in_cnt_r == (len_r - {{(LEN_W-1){1'b0}}, 1'b1}));
    flush_last_s = (flush_cnt_r == FLUSH_LAST);
    count_s      = conv_valid_out && ((state_r == ST_STREAM) || (state_r == ST_FLUSH) ||
                                      (state_r == ST_DRAIN));
    next_state_s = state_r;
    if (abort) begin
      next_state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            next_state_s = (frame_len == {LEN_W{1'b0}}) ? ST_DONE : ST_STREAM;
          end else begin
            next_state_s = ST_IDLE;
          end
        end
        ST_STREAM: next_state_s = in_last_s ? ST_FLUSH : ST_STREAM;
        ST_FLUSH:  next_state_s = flush_last_s ? ST_DRAIN : ST_FLUSH;
        ST_DRAIN:  next_state_s = (out_cnt_r == total_s) ? ST_DONE : ST_DRAIN;
        ST_DONE:   next_state_s = ST_IDLE;
        default:   next_state_s = ST_IDLE;
      endcase
    end
  end

  // State register with the status flags derived from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      s_ready <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= next_state_s;
      s_ready <= (next_state_s == ST_STREAM);
      busy    <= (next_state_s != ST_IDLE);
      done    <= (next_state_s == ST_DONE);
    end
  end

  // Shadow bank takes host writes at any time; the active bank copies it only on an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_TAPS; k++) shadow_r[k] <= {DATA_WIDTH{1'b0}};
      conv_h <= {(N_TAPS*DATA_WIDTH){1'b0}};
    end else begin
      if (coef_wr_en && ({1'b0, coef_addr} < TAP_COUNT)) shadow_r[coef_addr] <= coef_data;
      if (start_ok_s) begin
        for (int k = 0; k < N_TAPS; k++) conv_h[k*DATA_WIDTH +: DATA_WIDTH] <= shadow_r[k];
      end
    end
  end

  // Input side: frame length latch, sample/flush beat generation and their counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_r         <= {LEN_W{1'b0}};
      in_cnt_r      <= {LEN_W{1'b0}};
      flush_cnt_r   <= {LEN_W{1'b0}};
      conv_valid_in <= 1'b0;
      conv_x        <= {DATA_WIDTH{1'b0}};
    end else if (abort) begin
      conv_valid_in <= 1'b0;
      conv_x        <= {DATA_WIDTH{1'b0}};
    end else begin
      conv_valid_in <= 1'b0;
      conv_x        <= {DATA_WIDTH{1'b0}};
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            len_r       <= frame_len;
            in_cnt_r    <= {LEN_W{1'b0}};
            flush_cnt_r <= {LEN_W{1'b0}};
          end
        end
        ST_STREAM: begin
          if (accept_s) begin
            conv_valid_in <= 1'b1;
            conv_x        <= s_data;
            in_cnt_r      <= in_cnt_r + {{(LEN_W-1){1'b0}}, 1'b1};
          end
        end
        ST_FLUSH: begin
          conv_valid_in <= 1'b1;
          flush_cnt_r   <= flush_cnt_r + {{(LEN_W-1){1'b0}}, 1'b1};
        end
        default: begin
          conv_valid_in <= 1'b0;
        end
      endcase
    end
  end

  // Output side: outputs only count while a frame is live, so stale results after abort vanish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt_r <= {(LEN_W+1){1'b0}};
      m_valid   <= 1'b0;
      m_data    <= {DATA_WIDTH{1'b0}};
      m_last    <= 1'b0;
    end else if (abort) begin
      m_valid <= 1'b0;
      m_data  <= {DATA_WIDTH{1'b0}};
      m_last  <= 1'b0;
    end else begin
      m_valid <= count_s;
      m_data  <= count_s ? conv_y : {DATA_WIDTH{1'b0}};
      m_last  <= count_s && (out_cnt_r == (total_s - {{LEN_W{1'b0}}, 1'b1}));
      if (start_ok_s) begin
        out_cnt_r <= {(LEN_W+1){1'b0}};
      end else if (count_s) begin
        out_cnt_r <= out_cnt_r + {{LEN_W{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Directed bench for conv_frame_sequencer with a small behavioural FIR datapath attached.
module tb_conv_frame_sequencer;
  localparam int DW = 16;
  localparam int NT = 16;
  localparam int LW = 16;
  localparam int AW = $clog2(NT);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0;
  logic [LW-1:0] frame_len = '0;
  logic coef_wr_en = 1'b0;
  logic [AW-1:0] coef_addr = '0;
  logic [DW-1:0] coef_data = '0;
  logic s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic s_ready, conv_valid_in, conv_valid_out, m_valid, m_last, busy, done;
  logic [DW-1:0] conv_x, conv_y, m_data;
  logic [NT*DW-1:0] conv_h;

  logic inj = 1'b0;
  logic [DW-1:0] inj_y = 16'd99;
  logic cvo_m;
  logic [DW-1:0] y_m;
  logic [DW-1:0] hist [NT];

  int checks = 0, failures = 0;
  logic [DW-1:0] outq[$];
  int last_idx, last_cnt, done_cnt, done_after_last, cvi_cnt, run, max_run, mv_cnt, busy_cnt;
  bit last_prev;

  always #5 clk = ~clk;

  conv_frame_sequencer #(.DATA_WIDTH(DW), .N_TAPS(NT), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .frame_len(frame_len),
    .coef_wr_en(coef_wr_en), .coef_addr(coef_addr), .coef_data(coef_data),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .conv_valid_in(conv_valid_in), .conv_x(conv_x), .conv_h(conv_h),
    .conv_valid_out(conv_valid_out), .conv_y(conv_y),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .busy(busy), .done(done)
  );

  assign conv_valid_out = cvo_m | inj;
  assign conv_y         = inj ? inj_y : y_m;

  // Behavioural FIR with one cycle of latency; history cleared between frames.
  always @(posedge clk or negedge rst_n) begin
    int acc;
    if (!rst_n) begin
      cvo_m <= 1'b0;
      y_m   <= '0;
      for (int k = 0; k < NT; k++) hist[k] <= '0;
    end else begin
      cvo_m <= conv_valid_in;
      if (!busy) begin
        for (int k = 0; k < NT; k++) hist[k] <= '0;
      end else if (conv_valid_in) begin
        acc = $signed(conv_x) * $signed(conv_h[0 +: DW]);
        for (int k = 1; k < NT; k++) acc += $signed(hist[k-1]) * $signed(conv_h[k*DW +: DW]);
        y_m <= acc[DW-1:0];
        hist[0] <= conv_x;
        for (int k = 1; k < NT; k++) hist[k] <= hist[k-1];
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid) begin
        outq.push_back(m_data);
        mv_cnt++;
        if (m_last) begin last_idx = outq.size() - 1; last_cnt++; end
      end
      if (done) begin done_cnt++; if (last_prev) done_after_last++; end
      last_prev = m_valid && m_last;
      if (busy) busy_cnt++;
      if (conv_valid_in) begin cvi_cnt++; run++; if (run > max_run) max_run = run; end
      else run = 0;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_mon();
    outq.delete();
    last_idx = -1; last_cnt = 0; done_cnt = 0; done_after_last = 0; cvi_cnt = 0;
    run = 0; max_run = 0; mv_cnt = 0; busy_cnt = 0; last_prev = 1'b0;
  endtask

  task automatic wr_coef(input int a, input int d);
    coef_wr_en = 1'b1; coef_addr = AW'(a); coef_data = DW'(d);
    cyc(1);
    coef_wr_en = 1'b0;
  endtask

  task automatic do_start(input int len);
    start = 1'b1; frame_len = LW'(len);
    cyc(1);
    start = 1'b0;
  endtask

  task automatic send(input int x, input bit gap);
    s_valid = 1'b1; s_data = DW'(x);
    cyc(1);
    s_valid = 1'b0;
    if (gap) cyc(1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin cyc(1); n++; end
    check_eq(tag, 64'(done_cnt != 0), 64'd1);
    cyc(2);
  endtask

  function automatic logic [63:0] outv(input int i);
    return (i < outq.size()) ? 64'(outq[i]) : 64'hFFFF_FFFF;
  endfunction

  initial begin
    int zsum;
    clear_mon();
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_sready", 64'(s_ready), 64'd0);
    check_eq("rst_cvi", 64'(conv_valid_in), 64'd0);
    check_eq("rst_mvalid", 64'(m_valid), 64'd0);
    check_eq("rst_h", 64'(conv_h == '0), 64'd1);

    // 1: identity filter, back-to-back samples
    wr_coef(0, 1);
    clear_mon();
    do_start(4);
    for (int i = 1; i <= 4; i++) send(i, 1'b0);
    wait_done("t1_done_timeout", 200);
    check_eq("t1_count", 64'(outq.size()), 64'd19);
    for (int i = 0; i < 4; i++) check_eq($sformatf("t1_out%0d", i), outv(i), 64'(i + 1));
    zsum = 0;
    for (int i = 4; i < outq.size(); i++) zsum += int'(outq[i] != '0);
    check_eq("t1_tail_zero", 64'(zsum), 64'd0);
    check_eq("t1_last_idx", 64'(last_idx), 64'd18);
    check_eq("t1_last_cnt", 64'(last_cnt), 64'd1);
    check_eq("t1_done_cnt", 64'(done_cnt), 64'd1);
    check_eq("t1_done_after_last", 64'(done_after_last), 64'd1);
    check_eq("t1_cvi_cnt", 64'(cvi_cnt), 64'd19);
    check_eq("t1_cvi_run", 64'(max_run), 64'd19);

    // 2: two-tap filter with bubbles between samples
    wr_coef(1, 1);
    clear_mon();
    do_start(3);
    send(5, 1'b1); send(6, 1'b1); send(7, 1'b1);
    wait_done("t2_done_timeout", 200);
    check_eq("t2_count", 64'(outq.size()), 64'd18);
    check_eq("t2_out0", outv(0), 64'd5);
    check_eq("t2_out1", outv(1), 64'd11);
    check_eq("t2_out2", outv(2), 64'd13);
    check_eq("t2_out3", outv(3), 64'd7);
    check_eq("t2_out4", outv(4), 64'd0);
    check_eq("t2_cvi_cnt", 64'(cvi_cnt), 64'd18);
    check_eq("t2_cvi_run", 64'(max_run), 64'd16);

    // 3: shadow write coincident with start, then writes during the frame
    wr_coef(1, 0);
    clear_mon();
    start = 1'b1; frame_len = LW'(2);
    coef_wr_en = 1'b1; coef_addr = AW'(0); coef_data = DW'(2);
    cyc(1);
    start = 1'b0; coef_wr_en = 1'b0;
    check_eq("t3_h0_old", 64'(conv_h[0 +: DW]), 64'd1);
    send(3, 1'b0);
    wr_coef(5, 7);
    check_eq("t3_h0_stable", 64'(conv_h[0 +: DW]), 64'd1);
    check_eq("t3_h5_stable", 64'(conv_h[5*DW +: DW]), 64'd0);
    send(4, 1'b0);
    wait_done("t3a_done_timeout", 200);
    check_eq("t3a_out0", outv(0), 64'd3);
    check_eq("t3a_out1", outv(1), 64'd4);
    clear_mon();
    do_start(1);
    check_eq("t3b_h0_new", 64'(conv_h[0 +: DW]), 64'd2);
    check_eq("t3b_h5_new", 64'(conv_h[5*DW +: DW]), 64'd7);
    send(5, 1'b0);
    wait_done("t3b_done_timeout", 200);
    check_eq("t3b_count", 64'(outq.size()), 64'd16);
    check_eq("t3b_out0", outv(0), 64'd10);
    check_eq("t3b_out5", outv(5), 64'd35);

    // 4: empty frame
    clear_mon();
    do_start(0);
    wait_done("t4_done_timeout", 20);
    cyc(3);
    check_eq("t4_busy_cycles", 64'(busy_cnt), 64'd1);
    check_eq("t4_done_cnt", 64'(done_cnt), 64'd1);
    check_eq("t4_cvi_cnt", 64'(cvi_cnt), 64'd0);
    check_eq("t4_mvalid_cnt", 64'(mv_cnt), 64'd0);

    // 5: abort during the flush phase, then a clean frame
    wr_coef(5, 0);
    wr_coef(0, 1);
    clear_mon();
    do_start(2);
    send(1, 1'b0); send(2, 1'b0);
    cyc(3);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    clear_mon();
    check_eq("t5_busy", 64'(busy), 64'd0);
    check_eq("t5_cvi", 64'(conv_valid_in), 64'd0);
    check_eq("t5_sready", 64'(s_ready), 64'd0);
    check_eq("t5_mvalid", 64'(m_valid), 64'd0);
    inj = 1'b1;
    cyc(2);
    inj = 1'b0;
    cyc(3);
    check_eq("t5_stale_mvalid", 64'(mv_cnt), 64'd0);
    check_eq("t5_no_done", 64'(done_cnt), 64'd0);
    check_eq("t5_h_kept", 64'(conv_h[0 +: DW]), 64'd1);
    clear_mon();
    do_start(3);
    send(1, 1'b0); send(2, 1'b0); send(3, 1'b0);
    wait_done("t5b_done_timeout", 200);
    check_eq("t5b_count", 64'(outq.size()), 64'd18);
    check_eq("t5b_out2", outv(2), 64'd3);
    check_eq("t5b_last_idx", 64'(last_idx), 64'd17);

    // 6: asynchronous reset in the middle of streaming
    do_start(4);
    send(1, 1'b0); send(2, 1'b0);
    check_eq("t6_busy_pre", 64'(busy), 64'd1);
    rst_n = 1'b0; start = 1'b1; frame_len = LW'(4);
    #1;
    check_eq("t6_busy_async", 64'(busy), 64'd0);
    check_eq("t6_sready_async", 64'(s_ready), 64'd0);
    check_eq("t6_h_async", 64'(conv_h == '0), 64'd1);
    cyc(1);
    check_eq("t6_start_ignored", 64'(busy), 64'd0);
    start = 1'b0;
    rst_n = 1'b1;
    cyc(1);
    clear_mon();
    do_start(1);
    check_eq("t6_shadow_cleared", 64'(conv_h == '0), 64'd1);
    send(5, 1'b0);
    wait_done("t6_done_timeout", 200);
    check_eq("t6_count", 64'(outq.size()), 64'd16);
    check_eq("t6_out0", outv(0), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
